// File: rtl/hps_va_pkg.sv
// Shared types and constants for the HPS vector-analyzer start-request block.
package hps_va_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_CMD  = 2'd0;
    localparam logic [1:0] ADDR_ACK  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    localparam int CAP_DONE = 0;
    localparam int CAP_OVR  = 1;
    localparam int CAP_TMO  = 2;

endpackage

// File: rtl/hps_va_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module hps_va_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hps_va_start_req.sv
// Avalon-MM slave that launches a four-phase request/acknowledge command to the
// vector-analyzer fabric. Define HPS_VA_START_TIMEOUT_EN to add the ack timeout.
module hps_va_start_req
    import hps_va_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [DATA_W-1:0] out_data,
    output logic              out_req,
    input  logic              ack_in
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_REL  = ST_REL;

    logic        ack_s;
    logic [1:0]  state;
    logic [2:0]  irq_mask;
    logic [2:0]  capture;
    logic [2:0]  cap_set;
    logic [2:0]  cap_clr;
    logic        wr_en;
    logic        busy;
    logic        tmo_hit;
    logic [15:0] data_ext;
    logic [31:0] rd_next;
    logic        unused_bits;

    hps_va_sync2 u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_s)
    );

    assign wr_en    = chipselect & ~write_n;
    assign busy     = (state != S_IDLE);
    assign data_ext = 16'(out_data);
    assign irq      = |(capture & irq_mask);

`ifdef HPS_VA_START_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit     = (state == S_REQ) && !ack_s && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_bits = ^writedata[31:DATA_W];

    // Held at zero outside REQ so every new request starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || state != S_REQ) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign unused_bits = ^{writedata[31:DATA_W], 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en && address == ADDR_CMD) begin
                        out_data <= writedata[DATA_W-1:0];
                        out_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        out_req <= 1'b0;
                        state   <= S_REL;
                    end else if (tmo_hit) begin
                        out_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_REL: begin
                    if (!ack_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    out_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cap_set           = '0;
        cap_set[CAP_DONE] = (state == S_REL) && !ack_s;
        cap_set[CAP_OVR]  = busy && wr_en && (address == ADDR_CMD);
        cap_set[CAP_TMO]  = tmo_hit;
        cap_clr           = (wr_en && address == ADDR_CAP) ? writedata[2:0] : 3'b000;
    end

    // Set terms are OR-ed after the clear so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture  <= '0;
            irq_mask <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | cap_set;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[2:0];
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_CMD:  rd_next = {15'b0, busy, data_ext};
            ADDR_ACK:  rd_next = {31'b0, ack_s};
            ADDR_MASK: rd_next = {29'b0, irq_mask};
            default:   rd_next = {29'b0, capture};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_hps_va_start_req.sv
// Self-checking bench for hps_va_start_req: handshake sequences plus a register table.
`timescale 1ns/1ps
module tb_hps_va_start_req;
    import hps_va_pkg::*;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [DATA_W-1:0] out_data;
    logic              out_req;
    logic              ack_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_read;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    hps_va_start_req #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_data   (out_data),
        .out_req    (out_req),
        .ack_in     (ack_in)
    );

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] expected;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected <no queued value>", name, readdata);
        end else begin
            expected = exp_q.pop_front();
            check_value(name, readdata, expected);
        end
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] expected, input string name);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = addr;
        exp_q.push_back(expected);
        @(negedge clk);
        chipselect = 1'b0;
        checkOutput(name);
    endtask

    task automatic wait_out_req(input logic level, input int limit, output int cycles);
        cycles = 0;
        while (out_req !== level && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic fabric_complete();
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ack_in = 1'b1;
        wait_out_req(1'b0, 20, n);
        @(negedge clk);
        ack_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int high_cycles;

        vecs[0] = '{ADDR_MASK, 32'hFFFF_FFFF, ADDR_MASK, 32'h0000_0007, 1'b1};
        vecs[1] = '{ADDR_MASK, 32'h0000_0006, ADDR_MASK, 32'h0000_0006, 1'b0};
        vecs[2] = '{ADDR_MASK, 32'h0000_0001, ADDR_MASK, 32'h0000_0001, 1'b1};
        vecs[3] = '{ADDR_MASK, 32'h0000_0000, ADDR_MASK, 32'h0000_0000, 1'b0};
        vecs[4] = '{ADDR_CAP,  32'h0000_0000, ADDR_CAP,  32'h0000_0001, 1'b0};
        vecs[5] = '{ADDR_MASK, 32'h0000_0001, ADDR_ACK,  32'h0000_0000, 1'b1};
        vecs[6] = '{ADDR_CAP,  32'hFFFF_FFFF, ADDR_CAP,  32'h0000_0000, 1'b0};

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        ack_in     = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_out_req", out_req, 0);
        check_value("reset_out_data", out_data, 0);
        check_value("reset_irq", irq, 0);
        check_value("reset_readdata", readdata, 0);
        reset = 1'b0;

        $display("[TB] basic handshake");
        applyStimulus(ADDR_MASK, 32'h1);
        applyStimulus(ADDR_CMD, 32'h0000_1234);
        check_value("req_rise", out_req, 1);
        check_value("req_data", out_data, 16'h1234);
        bus_read(ADDR_CMD, 32'h0001_1234, "status_busy");
        @(negedge clk);
        ack_in = 1'b1;
        wait_out_req(1'b0, 20, n);
        check_value("ack_to_req_fall", n, 3);
        bus_read(ADDR_ACK, 32'h1, "raw_ack_high");
        bus_read(ADDR_CAP, 32'h0, "cap_in_rel");
        @(negedge clk);
        ack_in = 1'b0;
        repeat (4) @(negedge clk);
        check_value("done_irq", irq, 1);
        bus_read(ADDR_CAP, 32'h1, "cap_done");
        bus_read(ADDR_CMD, 32'h0000_1234, "status_idle");

        $display("[TB] overrun while busy");
        applyStimulus(ADDR_CMD, 32'h0000_1234);
        applyStimulus(ADDR_CMD, 32'h0000_5555);
        check_value("ovr_data_kept", out_data, 16'h1234);
        bus_read(ADDR_CAP, 32'h3, "cap_ovr");
        applyStimulus(ADDR_CAP, 32'h2);
        bus_read(ADDR_CAP, 32'h1, "cap_ovr_cleared");
        fabric_complete();
        bus_read(ADDR_CMD, 32'h0000_1234, "ovr_idle");

        $display("[TB] done vs clear collision");
        applyStimulus(ADDR_CAP, 32'h7);
        bus_read(ADDR_CAP, 32'h0, "cap_all_cleared");
        applyStimulus(ADDR_CMD, 32'h0000_0042);
        @(negedge clk);
        ack_in = 1'b1;
        wait_out_req(1'b0, 20, n);
        @(negedge clk);
        ack_in = 1'b0;
        @(negedge clk);
        applyStimulus(ADDR_CAP, 32'h1);
        bus_read(ADDR_CAP, 32'h1, "set_beats_clear");
        applyStimulus(ADDR_CAP, 32'h1);
        bus_read(ADDR_CAP, 32'h0, "clear_alone");

        $display("[TB] reset mid-handshake");
        applyStimulus(ADDR_CMD, 32'h0000_BEEF);
        @(negedge clk);
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_MASK;
        writedata  = 32'h7;
        @(negedge clk);
        check_value("rst_out_req", out_req, 0);
        check_value("rst_readdata", readdata, 0);
        check_value("rst_out_data", out_data, 0);
        check_value("rst_irq", irq, 0);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_read(ADDR_MASK, 32'h0, "rst_beats_write");
        bus_read(ADDR_CAP, 32'h0, "rst_cap");
        ack_in = 1'b1;
        repeat (5) @(negedge clk);
        ack_in = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(ADDR_CAP, 32'h0, "late_ack_no_bit");
        check_value("late_ack_req", out_req, 0);

`ifdef HPS_VA_START_TIMEOUT_EN
        $display("[TB] timeout enabled");
        applyStimulus(ADDR_CMD, 32'h0000_00AA);
        wait_out_req(1'b0, 50, n);
        check_value("tmo_cycles", n, 8);
        bus_read(ADDR_CAP, 32'h4, "tmo_cap");
        bus_read(ADDR_CMD, 32'h0000_00AA, "tmo_idle");
`else
        $display("[TB] timeout disabled");
        applyStimulus(ADDR_CMD, 32'h0000_00AA);
        high_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (out_req === 1'b1) high_cycles++;
        end
        check_value("no_tmo_hold", high_cycles, 1000);
        bus_read(ADDR_CAP, 32'h0, "no_tmo_cap");
        bus_read(ADDR_CMD, 32'h0001_00AA, "no_tmo_busy");
`endif

        $display("[TB] register table");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(ADDR_CMD, 32'h0000_0001);
        fabric_complete();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, vecs[i].exp_read, $sformatf("table_read_%0d", i));
            check_value($sformatf("table_irq_%0d", i), irq, vecs[i].exp_irq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
